nav_cmd_arb: RTL and testbench
==============================

NAV_CMD_ARB -- requirements
Module: nav_cmd_arb

Interface
REQ-001 Parameter NUM_SRC, default 2, number of command sources (legal range 2..4).
REQ-002 Parameter HDNG_W, default 12, width of the signed heading field per source.
REQ-003 Parameter TMO_W, default 20, width of the move watchdog counter; the timeout is 2^TMO_W-1 cycles.
REQ-004 clk  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 src_sel  input  2  index of the source allowed to issue commands; sampled only in IDLE.
REQ-007 src_hdng  input  NUM_SRC*HDNG_W  packed signed desired headings; source i occupies bits [i*HDNG_W +: HDNG_W].
REQ-008 src_strt_hdng  input  NUM_SRC  per-source single-cycle heading-start strobes.
REQ-009 src_strt_mv  input  NUM_SRC  per-source single-cycle move-start strobes.
REQ-010 src_stp_lft, src_stp_rght  input  NUM_SRC each  per-source stop-at-left/right-opening qualifiers.
REQ-011 mv_cmplt  input  1  single-cycle completion pulse from the navigate unit.
REQ-012 clr_err  input  1  clears drop_err.
REQ-013 dsrd_hdng  output  HDNG_W  registered heading sent to navigate.
REQ-014 strt_hdng, strt_mv  output  1 each  single-cycle start pulses to navigate.
REQ-015 stp_lft, stp_rght  output  1 each  registered stop qualifiers to navigate.
REQ-016 mv_cmplt_src  output  NUM_SRC  one-hot completion pulse routed back to the owning source.
REQ-017 busy  output  1  high while a command is outstanding.
REQ-018 owner  output  2  index of the source that owns the outstanding command.
REQ-019 drop_err  output  1  sticky flag: a strobe was discarded.
REQ-020 tmo_err  output  1  single-cycle pulse on watchdog expiry.

Function
REQ-021 The FSM shall have three states: IDLE, HDNG (heading command outstanding) and MOVE (move command outstanding).
REQ-022 In IDLE, a strobe on the source selected by src_sel shall be accepted; the block shall latch owner=src_sel and dsrd_hdng=that source's heading field, and move to HDNG (strt_hdng) or MOVE (strt_mv).
REQ-023 strt_hdng/strt_mv shall pulse high for exactly one cycle, on the cycle after the accepting edge (latency 1).
REQ-024 If strt_hdng and strt_mv arrive together from the accepted source, the heading command shall win and the move strobe shall be dropped.
REQ-025 On a strt_mv accept, stp_lft/stp_rght shall latch the owner's qualifiers and hold them until the next move accept; a heading accept shall leave them unchanged.
REQ-026 dsrd_hdng shall hold its value until the next accept, regardless of source input changes.
REQ-027 In HDNG or MOVE, mv_cmplt shall pulse mv_cmplt_src[owner] in the same cycle (combinational) and return the FSM to IDLE on that edge.
REQ-028 mv_cmplt received in IDLE shall be ignored, with no mv_cmplt_src pulse.
REQ-029 drop_err shall set on any of: a strobe while busy; a strobe from a non-selected source in IDLE; the losing strobe under REQ-024.
REQ-030 clr_err shall clear drop_err; if a set condition coincides with clr_err, set shall win.
REQ-031 Changes to src_sel while busy shall not change owner or routing.
REQ-032 busy shall equal (state != IDLE); it shall rise on the cycle after the accepting edge.

Reset
REQ-033 Asserting rst_n low shall, asynchronously and at any time including mid-command, force: state=IDLE, dsrd_hdng=0, strt_hdng=0, strt_mv=0, stp_lft=0, stp_rght=0, owner=0, busy=0, drop_err=0, tmo_err=0, watchdog=0.
REQ-034 mv_cmplt_src shall be 0 while in reset.

Configuration
REQ-035 With macro NAV_ARB_TMO_EN defined, a TMO_W-bit watchdog shall clear on accept and increment each cycle in HDNG/MOVE; on reaching all-ones it shall pulse tmo_err for one cycle, return to IDLE, and issue no mv_cmplt_src pulse.
REQ-036 Without NAV_ARB_TMO_EN, no watchdog logic shall exist, tmo_err shall be tied 0, and the block shall wait indefinitely for mv_cmplt.

Verification
REQ-037 NUM_SRC=2, src_sel=0, src_hdng[11:0]=12'h3FF, pulse src_strt_hdng[0] -> one cycle later strt_hdng=1 for 1 cycle, dsrd_hdng=12'h3FF, busy=1, owner=0.
REQ-038 src_sel=1, src_stp_lft[1]=1, pulse src_strt_mv[1], later mv_cmplt -> strt_mv pulse, stp_lft=1, mv_cmplt_src=2'b10 in the mv_cmplt cycle, busy=0 the next cycle.
REQ-039 While busy, pulse src_strt_mv[0] and change src_sel -> no strt_mv pulse, owner unchanged, drop_err=1 until clr_err.
REQ-040 Simultaneous src_strt_hdng[0] and src_strt_mv[0] in IDLE -> only strt_hdng pulses, drop_err=1.
REQ-041 NAV_ARB_TMO_EN, TMO_W=4, no mv_cmplt -> tmo_err pulses 15 cycles after the accept, busy=0, no mv_cmplt_src pulse.
REQ-042 Assert rst_n low during MOVE -> all outputs at their REQ-033 values immediately; a later mv_cmplt produces no mv_cmplt_src pulse.

Source files
------------

// File: rtl/nav_cmd_arb_if.sv
// Command bus between the navigation command sources and the arbiter.
// master: the side that drives the per-source requests (sources / bench).
// slave : the arbiter that grants one source and talks to the navigate unit.
interface nav_cmd_arb_if #(
  parameter int NUM_SRC = 2,
  parameter int HDNG_W  = 12
);
  // Source side
  logic [1:0]              src_sel;
  logic [NUM_SRC*HDNG_W-1:0] src_hdng;
  logic [NUM_SRC-1:0]      src_strt_hdng;
  logic [NUM_SRC-1:0]      src_strt_mv;
  logic [NUM_SRC-1:0]      src_stp_lft;
  logic [NUM_SRC-1:0]      src_stp_rght;
  logic                    mv_cmplt;
  logic                    clr_err;
  // Navigate / status side
  logic [HDNG_W-1:0]       dsrd_hdng;
  logic                    strt_hdng;
  logic                    strt_mv;
  logic                    stp_lft;
  logic                    stp_rght;
  logic [NUM_SRC-1:0]      mv_cmplt_src;
  logic                    busy;
  logic [1:0]              owner;
  logic                    drop_err;
  logic                    tmo_err;

  modport master (
    output src_sel, src_hdng, src_strt_hdng, src_strt_mv, src_stp_lft,
           src_stp_rght, mv_cmplt, clr_err,
    input  dsrd_hdng, strt_hdng, strt_mv, stp_lft, stp_rght, mv_cmplt_src,
           busy, owner, drop_err, tmo_err
  );

  modport slave (
    input  src_sel, src_hdng, src_strt_hdng, src_strt_mv, src_stp_lft,
           src_stp_rght, mv_cmplt, clr_err,
    output dsrd_hdng, strt_hdng, strt_mv, stp_lft, stp_rght, mv_cmplt_src,
           busy, owner, drop_err, tmo_err
  );
endinterface

// File: rtl/nav_cmd_arb.sv
// nav_cmd_arb: grants one of NUM_SRC command sources access to the navigate
// unit, forwards a single heading or move command, and routes the completion
// pulse back to the source that issued it. Strobes that cannot be honoured
// are discarded and flagged on the sticky drop_err.
// Optional feature: define NAV_ARB_TMO_EN to add a TMO_W-bit move watchdog
// that abandons a command after 2^TMO_W-1 cycles and pulses tmo_err.
module nav_cmd_arb #(
  parameter int NUM_SRC = 2,
  parameter int HDNG_W  = 12,
  parameter int TMO_W   = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  nav_cmd_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, HDNG, MOVE} state_e;

  // Reject illegal configurations at elaboration time.
  if (NUM_SRC < 2 || NUM_SRC > 4 || TMO_W < 1) begin : g_bad_cfg
    $error("nav_cmd_arb: NUM_SRC must be 2..4 and TMO_W >= 1");
  end

  state_e              state_q, state_d;
  logic [HDNG_W-1:0]   dsrd_hdng_q, dsrd_hdng_d;
  logic                strt_hdng_q, strt_hdng_d;
  logic                strt_mv_q, strt_mv_d;
  logic                stp_lft_q, stp_lft_d;
  logic                stp_rght_q, stp_rght_d;
  logic [1:0]          owner_q, owner_d;
  logic                drop_err_q, drop_err_d;
  logic                tmo_err_q, tmo_err_d;

  logic [NUM_SRC-1:0]  sel_mask;
  logic [HDNG_W-1:0]   sel_hdng;
  logic                sel_strt_hdng, sel_strt_mv, sel_stp_lft, sel_stp_rght;
  logic                oth_strobe, any_strobe, drop_set;
  logic [NUM_SRC-1:0]  mv_cmplt_src_c;

  // Decode src_sel into a mask and pick out the selected source's fields;
  // an out-of-range src_sel selects nothing, so every strobe is foreign.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    sel_mask = '0;
    sel_hdng = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.src_sel == 2'(i)) begin
        sel_mask[i] = 1'b1;
        sel_hdng    = bus.src_hdng[i*HDNG_W +: HDNG_W];
      end
    end
  end

  assign sel_strt_hdng = |(bus.src_strt_hdng & sel_mask);
  assign sel_strt_mv   = |(bus.src_strt_mv   & sel_mask);
  assign sel_stp_lft   = |(bus.src_stp_lft   & sel_mask);
  assign sel_stp_rght  = |(bus.src_stp_rght  & sel_mask);
  assign any_strobe    = |(bus.src_strt_hdng | bus.src_strt_mv);
  assign oth_strobe    = |((bus.src_strt_hdng | bus.src_strt_mv) & ~sel_mask);

`ifdef NAV_ARB_TMO_EN
  logic [TMO_W-1:0] wd_q, wd_d;
  logic [TMO_W-1:0] wd_inc;
  assign wd_inc = wd_q + 1'b1;
`endif

  // Next-state logic: accept in IDLE, wait for completion (or timeout)
  // while a command is outstanding, and collect discarded strobes.
  always_comb begin
    state_d     = state_q;
    dsrd_hdng_d = dsrd_hdng_q;
    strt_hdng_d = 1'b0;
    strt_mv_d   = 1'b0;
    stp_lft_d   = stp_lft_q;
    stp_rght_d  = stp_rght_q;
    owner_d     = owner_q;
    drop_set    = 1'b0;
    tmo_err_d   = 1'b0;
`ifdef NAV_ARB_TMO_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_strt_hdng) begin
          // Heading wins a tie; a simultaneous move strobe is discarded.
          state_d     = HDNG;
          strt_hdng_d = 1'b1;
          dsrd_hdng_d = sel_hdng;
          owner_d     = bus.src_sel;
          drop_set    = sel_strt_mv;
`ifdef NAV_ARB_TMO_EN
          wd_d        = '0;
`endif
        end else if (sel_strt_mv) begin
          state_d     = MOVE;
          strt_mv_d   = 1'b1;
          dsrd_hdng_d = sel_hdng;
          owner_d     = bus.src_sel;
          stp_lft_d   = sel_stp_lft;
          stp_rght_d  = sel_stp_rght;
`ifdef NAV_ARB_TMO_EN
          wd_d        = '0;
`endif
        end
        if (oth_strobe) drop_set = 1'b1;
      end
      HDNG, MOVE: begin
        // Only one command may be outstanding; anything else is dropped.
        drop_set = any_strobe;
        if (bus.mv_cmplt) begin
          state_d = IDLE;
        end
`ifdef NAV_ARB_TMO_EN
        else begin
          wd_d = wd_inc;
          if (wd_inc == '1) begin
            state_d   = IDLE;
            tmo_err_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // A new drop in the same cycle as clr_err must not be lost.
    drop_err_d = drop_set | (drop_err_q & ~bus.clr_err);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dsrd_hdng_q <= '0;
      strt_hdng_q <= 1'b0;
      strt_mv_q   <= 1'b0;
      stp_lft_q   <= 1'b0;
      stp_rght_q  <= 1'b0;
      owner_q     <= '0;
      drop_err_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      // NOTE: flops use non-blocking assignments so every register samples
      // the pre-edge values regardless of statement order.
      state_q     <= state_d;
      dsrd_hdng_q <= dsrd_hdng_d;
      strt_hdng_q <= strt_hdng_d;
      strt_mv_q   <= strt_mv_d;
      stp_lft_q   <= stp_lft_d;
      stp_rght_q  <= stp_rght_d;
      owner_q     <= owner_d;
      drop_err_q  <= drop_err_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

`ifdef NAV_ARB_TMO_EN
  // Watchdog counter for the outstanding command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  // Completion routing: combinational, and only while a command is owned.
  always_comb begin
    mv_cmplt_src_c = '0;
    if (state_q != IDLE && bus.mv_cmplt) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (owner_q == 2'(i)) mv_cmplt_src_c[i] = 1'b1;
      end
    end
  end

  assign bus.dsrd_hdng    = dsrd_hdng_q;
  assign bus.strt_hdng    = strt_hdng_q;
  assign bus.strt_mv      = strt_mv_q;
  assign bus.stp_lft      = stp_lft_q;
  assign bus.stp_rght     = stp_rght_q;
  assign bus.owner        = owner_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.drop_err     = drop_err_q;
  assign bus.mv_cmplt_src = mv_cmplt_src_c;
  assign bus.tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_nav_cmd_arb.sv
// Directed testbench for nav_cmd_arb (NUM_SRC=2, HDNG_W=12, TMO_W=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_nav_cmd_arb;
  localparam int NUM_SRC = 2;
  localparam int HDNG_W  = 12;
  localparam int TMO_W   = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  nav_cmd_arb_if #(.NUM_SRC(NUM_SRC), .HDNG_W(HDNG_W)) bus ();

  nav_cmd_arb #(.NUM_SRC(NUM_SRC), .HDNG_W(HDNG_W), .TMO_W(TMO_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    bus.src_strt_hdng = '0;
    bus.src_strt_mv   = '0;
    bus.clr_err       = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},      32'(bus.busy), 0);
    check({tag, " owner"},     32'(bus.owner), 0);
    check({tag, " dsrd_hdng"}, 32'(bus.dsrd_hdng), 0);
    check({tag, " strt"},      32'({bus.strt_hdng, bus.strt_mv}), 0);
    check({tag, " stp"},       32'({bus.stp_lft, bus.stp_rght}), 0);
    check({tag, " errs"},      32'({bus.drop_err, bus.tmo_err}), 0);
    check({tag, " cmplt_src"}, 32'(bus.mv_cmplt_src), 0);
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.src_sel       = 2'd0;
    bus.src_hdng      = '0;
    bus.src_stp_lft   = '0;
    bus.src_stp_rght  = '0;
    bus.mv_cmplt      = 1'b0;
    clear_strobes();
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Heading accept from source 0.
    bus.src_hdng      = {12'h123, 12'h3FF};
    bus.src_strt_hdng = 2'b01;
    tick();
    clear_strobes();
    check("hdng strt_hdng", 32'(bus.strt_hdng), 1);
    check("hdng strt_mv",   32'(bus.strt_mv), 0);
    check("hdng dsrd",      32'(bus.dsrd_hdng), 32'h3FF);
    check("hdng busy",      32'(bus.busy), 1);
    check("hdng owner",     32'(bus.owner), 0);
    bus.src_hdng[11:0] = 12'h0AA;
    tick();
    check("hdng pulse width", 32'(bus.strt_hdng), 0);
    check("hdng dsrd held",   32'(bus.dsrd_hdng), 32'h3FF);
    check("hdng no drop",     32'(bus.drop_err), 0);
    bus.mv_cmplt = 1'b1;
    #1;
    check("hdng cmplt_src", 32'(bus.mv_cmplt_src), 32'b01);
    tick();
    bus.mv_cmplt = 1'b0;
    check("hdng idle after cmplt", 32'(bus.busy), 0);

    // Move accept from source 1 with stop-left.
    bus.src_sel     = 2'd1;
    bus.src_stp_lft = 2'b10;
    bus.src_strt_mv = 2'b10;
    tick();
    clear_strobes();
    check("mv strt_mv",   32'(bus.strt_mv), 1);
    check("mv strt_hdng", 32'(bus.strt_hdng), 0);
    check("mv stp",       32'({bus.stp_lft, bus.stp_rght}), 32'b10);
    check("mv owner",     32'(bus.owner), 1);
    check("mv dsrd",      32'(bus.dsrd_hdng), 32'h123);
    bus.src_stp_lft = 2'b00;
    tick();
    check("mv pulse width", 32'(bus.strt_mv), 0);
    check("mv stp held",    32'(bus.stp_lft), 1);

    // Strobe while busy and src_sel change: dropped, ownership kept.
    bus.src_sel     = 2'd0;
    bus.src_strt_mv = 2'b01;
    tick();
    clear_strobes();
    check("busy strobe no start", 32'({bus.strt_hdng, bus.strt_mv}), 0);
    check("busy owner kept",      32'(bus.owner), 1);
    check("busy drop_err",        32'(bus.drop_err), 1);
    tick();
    check("drop_err sticky", 32'(bus.drop_err), 1);
    bus.mv_cmplt = 1'b1;
    #1;
    check("mv cmplt_src routed", 32'(bus.mv_cmplt_src), 32'b10);
    tick();
    bus.mv_cmplt = 1'b0;
    check("mv idle after cmplt", 32'(bus.busy), 0);
    check("drop_err survives",   32'(bus.drop_err), 1);
    bus.clr_err = 1'b1;
    tick();
    clear_strobes();
    check("clr_err clears", 32'(bus.drop_err), 0);

    // Set coincident with clear: set wins (foreign strobe in IDLE).
    bus.clr_err       = 1'b1;
    bus.src_strt_hdng = 2'b10;
    tick();
    clear_strobes();
    check("set beats clr", 32'(bus.drop_err), 1);
    check("foreign no accept", 32'(bus.busy), 0);
    bus.clr_err = 1'b1;
    tick();
    clear_strobes();

    // Out-of-range src_sel selects nobody.
    bus.src_sel       = 2'd2;
    bus.src_strt_hdng = 2'b01;
    tick();
    clear_strobes();
    check("bad sel no accept", 32'(bus.busy), 0);
    check("bad sel drop",      32'(bus.drop_err), 1);
    bus.clr_err = 1'b1;
    tick();
    clear_strobes();

    // mv_cmplt in IDLE is ignored.
    bus.mv_cmplt = 1'b1;
    #1;
    check("idle cmplt ignored", 32'(bus.mv_cmplt_src), 0);
    tick();
    bus.mv_cmplt = 1'b0;
    check("idle cmplt stays idle", 32'(bus.busy), 0);

    // Simultaneous heading and move strobes: heading wins.
    bus.src_sel       = 2'd0;
    bus.src_hdng      = {12'h123, 12'h800};
    bus.src_strt_hdng = 2'b01;
    bus.src_strt_mv   = 2'b01;
    tick();
    clear_strobes();
    check("tie strt_hdng",  32'(bus.strt_hdng), 1);
    check("tie strt_mv",    32'(bus.strt_mv), 0);
    check("tie drop_err",   32'(bus.drop_err), 1);
    check("tie dsrd",       32'(bus.dsrd_hdng), 32'h800);
    check("tie stp kept",   32'(bus.stp_lft), 1);

`ifdef NAV_ARB_TMO_EN
    // Watchdog: expiry shows 15 cycles after the accepting edge.
    for (int i = 0; i < 14; i++) tick();
    check("tmo not yet",      32'(bus.tmo_err), 0);
    check("tmo still busy",   32'(bus.busy), 1);
    tick();
    check("tmo pulse",        32'(bus.tmo_err), 1);
    check("tmo busy low",     32'(bus.busy), 0);
    check("tmo no cmplt_src", 32'(bus.mv_cmplt_src), 0);
    tick();
    check("tmo one cycle",    32'(bus.tmo_err), 0);
`else
    // No watchdog: the command waits indefinitely.
    for (int i = 0; i < 20; i++) tick();
    check("no tmo busy",   32'(bus.busy), 1);
    check("no tmo_err",    32'(bus.tmo_err), 0);
    bus.mv_cmplt = 1'b1;
    tick();
    bus.mv_cmplt = 1'b0;
    check("no tmo cmplt", 32'(bus.busy), 0);
`endif

    // Asynchronous reset in the middle of a move.
    bus.clr_err = 1'b1;
    tick();
    clear_strobes();
    bus.src_sel      = 2'd1;
    bus.src_stp_rght = 2'b10;
    bus.src_strt_mv  = 2'b10;
    tick();
    clear_strobes();
    check("pre-reset busy", 32'(bus.busy), 1);
    check("pre-reset stp",  32'({bus.stp_lft, bus.stp_rght}), 32'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    bus.mv_cmplt = 1'b1;
    #1;
    check("reset cmplt_src", 32'(bus.mv_cmplt_src), 0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.mv_cmplt = 1'b0;
    tick();
    bus.mv_cmplt = 1'b1;
    #1;
    check("post-reset cmplt ignored", 32'(bus.mv_cmplt_src), 0);
    tick();
    bus.mv_cmplt = 1'b0;
    check("post-reset idle", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
